// File: rtl/scale_pipe.sv
// -----------------------------------------------------------------------------
// scale_pipe
// Pipelined pixel-coordinate scaler. It sits between the video timing generator
// and the frame-buffer BRAM. It maps a raster position (hcount, vcount) onto the
// source image for an integer upscale factor F in 1..MAX_SCALE. It then produces
// the linear BRAM read address and an in-image valid flag.
//
// The factor (and, when centering is enabled, the image offsets) is latched only
// on the raster origin (0,0). This prevents a scale change from tearing a frame.
//
// Optional feature macro: SCALE_PIPE_CENTER_EN
//   defined   -> the image is centred in the H_ACTIVE x V_ACTIVE display
//   undefined -> the image is anchored at the top-left corner (offsets = 0)
//
// Ports
//   clk_in             in   pixel clock
//   rst_in             in   synchronous reset, active-high
//   scale_in           in   requested factor code (factor = scale_in + 1)
//   hcount_in          in   raster x (11 bits)
//   vcount_in          in   raster y (10 bits)
//   active_draw_in     in   raster is inside the active display region
//   scaled_hcount_out  out  source x, 0 when invalid
//   scaled_vcount_out  out  source y, 0 when invalid
//   addr_out           out  scaled_v*IMG_W + scaled_h, 0 when invalid
//   valid_addr_out     out  pixel lies inside the scaled image
//   active_scale_out   out  factor code currently in effect (F-1)
//
// Latency is 3 clocks, with one result per clock and no stalls:
//   S1 registers the inputs and the F/offsets,
//   S2 subtracts the offsets and range-checks,
//   S3 divides by F and forms the address.
// -----------------------------------------------------------------------------
module scale_pipe #(
  parameter int IMG_W     = 240,
  parameter int IMG_H     = 320,
  parameter int MAX_SCALE = 4,
  parameter int SCALE_W   = 2,
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int ADDR_W    = $clog2(IMG_W * IMG_H)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [SCALE_W-1:0] scale_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               active_draw_in,
  output logic [10:0]        scaled_hcount_out,
  output logic [9:0]         scaled_vcount_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               valid_addr_out,
  output logic [SCALE_W-1:0] active_scale_out
);

`ifdef SCALE_PIPE_CENTER_EN
  localparam bit CENTER_EN = 1'b1;
`else
  localparam bit CENTER_EN = 1'b0;
`endif

  localparam int FW = (MAX_SCALE < 2) ? 1 : $clog2(MAX_SCALE + 1);
  // 14-bit compare width: off + IMG_H*F reaches 1280 at F=4.
  // This leaves ample headroom above 2047.
  localparam int CW = 14;
  // Reciprocal precision. With k=24, x*ceil(2^k/F) >> k is exact for every
  // x < 2^11 and every small F, because the rounding error x*e/2^k stays < 1/F.
  localparam int RK = 24;
  localparam int RW = RK + 1;
  localparam int PW = 11 + RW;

  // Centering offset for one axis: max(0, (active - img*F) / 2), floor division.
  function automatic logic [CW-1:0] calc_off(input int active_px, input int img_px,
                                             input logic [FW-1:0] f);
    int span;
    span = img_px * int'(f);
    if (CENTER_EN && (active_px > span)) calc_off = CW'((active_px - span) / 2);
    else                                 calc_off = '0;
  endfunction

  // Reciprocal table: ceil(2^RK / F) for each legal F. Unused codes read as 0.
  logic [RW-1:0] w_recip [0:(1 << FW) - 1];
  for (genvar g = 0; g < (1 << FW); g++) begin : g_recip
    if (g >= 1 && g <= MAX_SCALE) begin : g_used
      assign w_recip[g] = RW'(((1 << RK) + g - 1) / g);
    end else begin : g_unused
      assign w_recip[g] = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame latch
  // ---------------------------------------------------------------------------
  logic               w_frame_start;
  logic [SCALE_W:0]   w_req;
  logic [FW-1:0]      w_f_new;
  logic [FW-1:0]      w_f_eff;
  logic [CW-1:0]      w_off_h_new, w_off_v_new;
  logic [CW-1:0]      w_off_h_eff, w_off_v_eff;

  logic [FW-1:0]      r_f;
  logic [CW-1:0]      r_off_h, r_off_v;
  logic [SCALE_W-1:0] r_active_scale;

  // New factor/offsets, and the values that apply to the pixel on the inputs now.
  always_comb begin
    w_frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    w_req         = {1'b0, scale_in} + {{SCALE_W{1'b0}}, 1'b1};
    if (int'(w_req) > MAX_SCALE) w_f_new = FW'(MAX_SCALE);
    else                         w_f_new = FW'(w_req);
    w_off_h_new = calc_off(H_ACTIVE, IMG_W, w_f_new);
    w_off_v_new = calc_off(V_ACTIVE, IMG_H, w_f_new);
    // The origin pixel itself is scaled with the factor it causes to be latched.
    if (w_frame_start) begin
      w_f_eff     = w_f_new;
      w_off_h_eff = w_off_h_new;
      w_off_v_eff = w_off_v_new;
    end else begin
      w_f_eff     = r_f;
      w_off_h_eff = r_off_h;
      w_off_v_eff = r_off_v;
    end
  end

  // Factor/offset latch: updates only at the raster origin. Reset takes priority.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_f            <= FW'(1);
      r_off_h        <= '0;
      r_off_v        <= '0;
      r_active_scale <= '0;
    end else if (w_frame_start) begin
      r_f            <= w_f_new;
      r_off_h        <= w_off_h_new;
      r_off_v        <= w_off_v_new;
      r_active_scale <= SCALE_W'(w_f_new - FW'(1));
    end
  end

  // ---------------------------------------------------------------------------
  // S1: register the raster inputs together with the factor/offsets they use
  // ---------------------------------------------------------------------------
  logic [10:0]   r1_h;
  logic [9:0]    r1_v;
  logic          r1_act;
  logic [FW-1:0] r1_f;
  logic [CW-1:0] r1_off_h, r1_off_v;

  // Stage 1 capture. Reset clears the active bit, which flushes this stage.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r1_h     <= '0;
      r1_v     <= '0;
      r1_act   <= 1'b0;
      r1_f     <= FW'(1);
      r1_off_h <= '0;
      r1_off_v <= '0;
    end else begin
      r1_h     <= hcount_in;
      r1_v     <= vcount_in;
      r1_act   <= active_draw_in;
      r1_f     <= w_f_eff;
      r1_off_h <= w_off_h_eff;
      r1_off_v <= w_off_v_eff;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: offset subtraction and range check
  // ---------------------------------------------------------------------------
  logic [CW-1:0] w_h_ext, w_v_ext;
  logic [CW-1:0] w_dx, w_dy;
  logic [CW-1:0] w_span_h, w_span_v;
  logic          w_valid;

  // Window test: off <= pos < off + IMG*F on both axes while drawing.
  always_comb begin
    w_h_ext  = CW'(r1_h);
    w_v_ext  = CW'(r1_v);
    w_dx     = w_h_ext - r1_off_h;
    w_dy     = w_v_ext - r1_off_v;
    w_span_h = CW'(IMG_W) * CW'(r1_f);
    w_span_v = CW'(IMG_H) * CW'(r1_f);
    w_valid  = r1_act
            && (w_h_ext >= r1_off_h) && (w_h_ext < (r1_off_h + w_span_h))
            && (w_v_ext >= r1_off_v) && (w_v_ext < (r1_off_v + w_span_v));
  end

  logic [10:0]   r2_x;
  logic [9:0]    r2_y;
  logic          r2_valid;
  logic [FW-1:0] r2_f;

  // Stage 2 capture. Relative coordinates are zeroed for out-of-image pixels.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r2_x     <= '0;
      r2_y     <= '0;
      r2_valid <= 1'b0;
      r2_f     <= FW'(1);
    end else begin
      r2_x     <= w_valid ? 11'(w_dx) : 11'd0;
      r2_y     <= w_valid ? 10'(w_dy) : 10'd0;
      r2_valid <= w_valid;
      r2_f     <= r1_f;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: reciprocal-multiply division and address generation
  // ---------------------------------------------------------------------------
  logic [RW-1:0]     w_rcp;
  logic [10:0]       w_qx;
  logic [9:0]        w_qy;
  logic [ADDR_W-1:0] w_addr;

  // floor(x/F) = (x * ceil(2^RK/F)) >> RK. Then address = y*IMG_W + x.
  always_comb begin
    w_rcp  = w_recip[r2_f];
    w_qx   = 11'((PW'(r2_x) * PW'(w_rcp)) >> RK);
    w_qy   = 10'((PW'(r2_y) * PW'(w_rcp)) >> RK);
    w_addr = ADDR_W'(32'(w_qy) * 32'(IMG_W) + 32'(w_qx));
  end

  logic [10:0]       r_scaled_h;
  logic [9:0]        r_scaled_v;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;

  // Output registers. Every output is forced to zero when the pixel is invalid.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_scaled_h <= '0;
      r_scaled_v <= '0;
      r_addr     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_scaled_h <= r2_valid ? w_qx   : 11'd0;
      r_scaled_v <= r2_valid ? w_qy   : 10'd0;
      r_addr     <= r2_valid ? w_addr : {ADDR_W{1'b0}};
      r_valid    <= r2_valid;
    end
  end

  assign scaled_hcount_out = r_scaled_h;
  assign scaled_vcount_out = r_scaled_v;
  assign addr_out          = r_addr;
  assign valid_addr_out    = r_valid;
  assign active_scale_out  = r_active_scale;

endmodule

// File: tb/tb_scale_pipe.sv
// Self-checking bench for scale_pipe.
// Every pixel driven pushes its expected result onto a scoreboard queue, which
// is tagged with the cycle the result is due. A monitor pops each entry and
// compares it 3 clocks later. Scenario tasks add inline checks on
// active_scale_out and on reset behaviour.
module tb_scale_pipe;

  localparam int IMG_W = 240;
  localparam int IMG_H = 320;
  localparam int H_ACT = 1280;
  localparam int V_ACT = 720;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [1:0]  scale_in = 2'd0;
  logic [10:0] hcount_in = 11'd0;
  logic [9:0]  vcount_in = 10'd0;
  logic        active_draw_in = 1'b0;
  logic [10:0] scaled_hcount_out;
  logic [9:0]  scaled_vcount_out;
  logic [16:0] addr_out;
  logic        valid_addr_out;
  logic [1:0]  active_scale_out;

  scale_pipe dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .scale_in          (scale_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .active_draw_in    (active_draw_in),
    .scaled_hcount_out (scaled_hcount_out),
    .scaled_vcount_out (scaled_vcount_out),
    .addr_out          (addr_out),
    .valid_addr_out    (valid_addr_out),
    .active_scale_out  (active_scale_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          h;
    int          v;
    logic [10:0] sh;
    logic [9:0]  sv;
    logic [16:0] addr;
    logic        vld;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_f = 1;
  int   m_offh = 0;
  int   m_offv = 0;

  // Reference model of one pixel, written directly from the mapping equations.
  function automatic exp_t model(input int h, input int v, input bit act,
                                 input int f, input int offh, input int offv, input int due);
    exp_t e;
    bit   ok;
    int   sh, sv;
    ok = act && (h >= offh) && (h < offh + IMG_W * f) && (v >= offv) && (v < offv + IMG_H * f);
    sh = ok ? (h - offh) / f : 0;
    sv = ok ? (v - offv) / f : 0;
    e.h = h; e.v = v; e.due = due;
    e.sh = 11'(sh); e.sv = 10'(sv);
    e.addr = 17'(sv * IMG_W + sh);
    e.vld = ok;
    return e;
  endfunction

  // Drive one pixel at the falling edge and record its expected result.
  task automatic drive(input int h, input int v, input bit act, input int sc, input bit rst);
    exp_t e;
    int   span;
    @(negedge clk_in);
    rst_in = rst; hcount_in = 11'(h); vcount_in = 10'(v);
    active_draw_in = act; scale_in = 2'(sc);
    if (rst) begin
      m_f = 1; m_offh = 0; m_offv = 0;
      foreach (q[i]) begin
        q[i].sh = 11'd0; q[i].sv = 10'd0; q[i].addr = 17'd0; q[i].vld = 1'b0;
      end
      e = model(h, v, 1'b0, 1, 0, 0, cyc + 3);
    end else begin
      if (h == 0 && v == 0) begin
        m_f = (sc + 1 > 4) ? 4 : sc + 1;
`ifdef SCALE_PIPE_CENTER_EN
        span = H_ACT - IMG_W * m_f; m_offh = (span > 0) ? span / 2 : 0;
        span = V_ACT - IMG_H * m_f; m_offv = (span > 0) ? span / 2 : 0;
`else
        span = 0; m_offh = span; m_offv = span;
`endif
      end
      e = model(h, v, act, m_f, m_offh, m_offv, cyc + 3);
    end
    q.push_back(e);
  endtask

  // Scoreboard monitor: compares each due entry just after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      cyc++;
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        checks++;
        if (scaled_hcount_out !== e.sh || scaled_vcount_out !== e.sv ||
            addr_out !== e.addr || valid_addr_out !== e.vld) begin
          errors++;
          $display("FAIL pixel(%0d,%0d): got h=%0d v=%0d addr=%0d vld=%0b, expected h=%0d v=%0d addr=%0d vld=%0b",
                   e.h, e.v, scaled_hcount_out, scaled_vcount_out, addr_out, valid_addr_out,
                   e.sh, e.sv, e.addr, e.vld);
        end
      end
    end
  end

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1'b1, 3, 1'b1);
      @(posedge clk_in); #2;
      checks++;
      if (valid_addr_out !== 1'b0 || active_scale_out !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: got vld=%0b scale=%0d, expected vld=0 scale=0",
                 valid_addr_out, active_scale_out);
      end
    end
    drive(0, 0, 1'b1, 0, 1'b0);
    drive(1, 0, 1'b1, 0, 1'b0);
    drive(239, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_f1;
    drive(0, 0, 1'b1, 0, 1'b0);
    drive(239, 319, 1'b1, 0, 1'b0);
    drive(240, 0, 1'b1, 0, 1'b0);
    drive(0, 320, 1'b1, 0, 1'b0);
    drive(100, 100, 1'b0, 0, 1'b0);
    drive(17, 33, 1'b1, 0, 1'b0);
  endtask

  task automatic test_f3;
    drive(0, 0, 1'b1, 2, 1'b0);
    @(posedge clk_in); #2;
    checks++;
    if (active_scale_out !== 2'd2) begin
      errors++;
      $display("FAIL f3_latch: got scale=%0d, expected 2", active_scale_out);
    end
    drive(5, 7, 1'b1, 2, 1'b0);
    drive(719, 959, 1'b1, 2, 1'b0);
    drive(720, 959, 1'b1, 2, 1'b0);
    drive(719, 960, 1'b1, 2, 1'b0);
  endtask

  task automatic test_midframe;
    drive(0, 0, 1'b1, 0, 1'b0);
    drive(100, 50, 1'b1, 3, 1'b0);
    drive(5, 5, 1'b1, 3, 1'b0);
    drive(239, 319, 1'b1, 3, 1'b0);
    @(posedge clk_in); #2;
    checks++;
    if (active_scale_out !== 2'd0) begin
      errors++;
      $display("FAIL midframe_hold: got scale=%0d, expected 0", active_scale_out);
    end
    drive(0, 0, 1'b1, 3, 1'b0);
    @(posedge clk_in); #2;
    checks++;
    if (active_scale_out !== 2'd3) begin
      errors++;
      $display("FAIL midframe_latch: got scale=%0d, expected 3", active_scale_out);
    end
    drive(8, 4, 1'b1, 3, 1'b0);
    drive(959, 1023, 1'b1, 3, 1'b0);
    drive(960, 4, 1'b1, 3, 1'b0);
  endtask

`ifdef SCALE_PIPE_CENTER_EN
  task automatic test_center;
    drive(0, 0, 1'b1, 1, 1'b0);
    drive(399, 40, 1'b1, 1, 1'b0);
    drive(400, 40, 1'b1, 1, 1'b0);
    drive(879, 679, 1'b1, 1, 1'b0);
    drive(880, 40, 1'b1, 1, 1'b0);
    drive(400, 39, 1'b1, 1, 1'b0);
  endtask
`endif

  task automatic test_midreset;
    drive(0, 0, 1'b1, 3, 1'b0);
    for (int i = 1; i <= 6; i++) drive(i * 37, i * 11, 1'b1, 3, 1'b0);
    drive(50, 50, 1'b1, 3, 1'b1);
    @(posedge clk_in); #2;
    checks++;
    if (active_scale_out !== 2'd0 || valid_addr_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got scale=%0d vld=%0b, expected scale=0 vld=0",
               active_scale_out, valid_addr_out);
    end
    for (int i = 0; i < 4; i++) drive(10 + i, 3, 1'b1, 3, 1'b0);
  endtask

  task automatic test_back_to_back;
    int h, v, sc;
    bit act;
    for (int i = 0; i < 300; i++) begin
      sc  = $urandom_range(0, 3);
      act = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 24) == 0) begin
        h = 0; v = 0;
      end else if ($urandom_range(0, 1) == 0) begin
        h = $urandom_range(0, 2047); v = $urandom_range(0, 1023);
      end else begin
        h = $urandom_range(0, 1000); v = $urandom_range(0, 1023);
      end
      drive(h, v, act, sc, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_f1();
    test_f3();
    test_midframe();
`ifdef SCALE_PIPE_CENTER_EN
    test_center();
`endif
    test_midreset();
    test_back_to_back();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_in);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
